// File: rtl/multi_pulse_counter.sv
// rtl/multi_pulse_counter.sv - multi-channel toggle-event counter with CDC sync, overflow flags and snapshot
// Toggle inputs are synchronized per channel; edges after the INIT settle window are counted.
module multi_pulse_counter #(
  parameter int NCH         = 4,
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      pulse_tgl,
  input  logic [NCH-1:0]      clr,
  input  logic                snap,
  output logic [NCH*CW-1:0]   cnt,
  output logic [NCH*CW-1:0]   snap_cnt,
  output logic                snap_vld,
  output logic [NCH-1:0]      evt,
  output logic [NCH-1:0]      ovf
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

  state_t          state_q, state_d;
  logic [2:0]      init_cnt_q, init_cnt_d;

  logic [NCH-1:0]  sync_q [SYNC_STAGES];
  logic [NCH-1:0]  hist_q;
  logic [NCH-1:0]  event_det;

  logic [NCH*CW-1:0] cnt_d;
  logic [NCH-1:0]    ovf_d;

  // FSM: INIT holds for SYNC_STAGES+1 cycles so the history flops absorb the reset-release level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= pulse_tgl;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign event_det = (sync_q[SYNC_STAGES-1] ^ hist_q) & {NCH{state_q == ST_RUN}};

  // A clear coinciding with an event restarts the count at 1 so the event is kept.
  always_comb begin
    cnt_d = cnt;
    ovf_d = ovf;
    for (int i = 0; i < NCH; i++) begin
      if (clr[i]) begin
        cnt_d[i*CW +: CW] = CW'(event_det[i]);
        ovf_d[i]          = 1'b0;
      end else if (event_det[i]) begin
        if (cnt[i*CW +: CW] == {CW{1'b1}}) begin
          ovf_d[i] = 1'b1;
          if (SATURATE == 0) begin
            cnt_d[i*CW +: CW] = '0;
          end
        end else begin
          cnt_d[i*CW +: CW] = cnt[i*CW +: CW] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      ovf      <= '0;
      evt      <= '0;
      snap_cnt <= '0;
      snap_vld <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      ovf      <= ovf_d;
      evt      <= event_det;
      snap_vld <= snap;
      if (snap) begin
        snap_cnt <= cnt;
      end
    end
  end

endmodule

// File: doc/multi_pulse_counter.md
MULTI_PULSE_COUNTER -- requirements
Module: multi_pulse_counter

Interface
REQ-001 Parameter NCH, default 4, number of independent channels (1..32).
REQ-002 Parameter CW, default 16, counter width per channel (2..32).
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth (2..4).
REQ-004 Parameter SATURATE, default 0, overflow mode: 0 = wrap, 1 = saturate at all-ones.
REQ-005 clk  input  1  sole clock; all outputs are registered on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pulse_tgl  input  NCH  per-channel toggle-encoded events from an unrelated clock domain; each level change is one event.
REQ-008 clr  input  NCH  per-channel synchronous clear, clk domain.
REQ-009 snap  input  1  synchronous request to capture all counts, clk domain.
REQ-010 cnt  output  NCH*CW  live counters; channel i occupies bits [i*CW +: CW].
REQ-011 snap_cnt  output  NCH*CW  snapshot of all counters, same packing as cnt.
REQ-012 snap_vld  output  1  one-cycle strobe: snap_cnt has been updated.
REQ-013 evt  output  NCH  one-cycle strobe per detected event.
REQ-014 ovf  output  NCH  sticky per-channel overflow flag.

Function
REQ-015 Each channel passes pulse_tgl[i] through a SYNC_STAGES-deep flop chain, followed by one history flop; an event is detected when the last sync stage differs from the history flop.
REQ-016 Control FSM states: INIT and RUN.
- Reset enters INIT.
- INIT lasts exactly SYNC_STAGES+1 cycles, counted by an internal counter; in INIT, event detection is masked and the history flops track the sync outputs.
- INIT then moves to RUN, which persists until the next reset.
REQ-017 In INIT, no change in pulse_tgl level, including a nonzero level at reset release, counts as an event.
REQ-018 In RUN, a detected event on channel i increments cnt[i] by 1 and asserts evt[i] for exactly one cycle, on the same clock edge.
REQ-019 Latency: a pulse_tgl change captured into sync stage 0 at edge k updates cnt and evt at edge k+SYNC_STAGES.
REQ-020 The source holds each toggle level for at least 2 clk periods; faster toggling is outside specification and may lose events.
REQ-021 Wrap mode (SATURATE=0): an event at all-ones sets cnt to 0 and sets ovf[i].
REQ-022 Saturate mode (SATURATE=1): an event at all-ones leaves cnt at all-ones and sets ovf[i].
REQ-023 ovf[i] stays set until clr[i] or reset.
REQ-024 clr[i] sets cnt[i] to 0 and clears ovf[i] on the next edge.
REQ-025 If clr[i] and an event on channel i occur in the same cycle, cnt[i] becomes 1, ovf[i] becomes 0, and evt[i] is asserted; the event is not lost.
REQ-026 On snap, snap_cnt loads all channels' cnt values as they stood before that edge, and snap_vld asserts for one cycle at that edge.
REQ-027 An event or clr occurring in the same cycle as snap is therefore excluded from the snapshot.
REQ-028 snap is honoured in both INIT and RUN.
REQ-029 Back-to-back snap cycles each produce a fresh snapshot and a snap_vld strobe.
REQ-030 Channels are fully independent; simultaneous events on all channels are all counted in the same cycle.

Reset
REQ-031 While rst_n is low, the following are 0: cnt, snap_cnt, snap_vld, evt, ovf, all sync and history flops, and the INIT counter; the FSM is in INIT.
REQ-032 Reset assertion mid-operation takes effect immediately, regardless of clk.
REQ-033 After release, the block re-runs INIT, and no stale events are counted.

Verification
REQ-034 NCH=4, SYNC_STAGES=2: hold pulse_tgl=4'b0101 through reset release -> after INIT, cnt all 0 and evt never asserted.
REQ-035 RUN: toggle ch0 once -> evt[0] high exactly 2 edges after capture, cnt[0]=1, other channels unchanged.
REQ-036 CW=4, SATURATE=0: 16 events on ch1 -> cnt[1]=0, ovf[1]=1; then clr[1] -> ovf[1]=0.
REQ-037 CW=4, SATURATE=1: 20 events on ch2 -> cnt[2]=15, ovf[2]=1.
REQ-038 cnt[3]=7, then clr[3] and an event on ch3 in the same cycle -> cnt[3]=1, evt[3]=1.
REQ-039 cnt[0]=5 with an event in the snap cycle -> snap_cnt ch0=5, cnt[0]=6, snap_vld one cycle; then assert rst_n low mid-run -> all outputs 0 immediately.
